// File: rtl/mem_mp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_mp_ctrl_if
// Description : Bundled request/response signals between NUM_PORTS
//               requesters and the multi-port memory controller.
//               All per-port fields are packed flat, port i at slice i.
//   valid  [NUM_PORTS]              request per port, held until ready
//   wr_rd  [NUM_PORTS]              1 = write, 0 = read
//   addr   [NUM_PORTS*ADDR_WIDTH]   word address per port
//   wdata  [NUM_PORTS*WIDTH]        write data per port
//   wstrb  [NUM_PORTS*(WIDTH/8)]    byte enables per port
//   ready  [NUM_PORTS]              one-cycle completion pulse
//   rdata  [WIDTH]                  read data, valid with ready
//   err    [1]                      out-of-range flag, valid with ready
// Modports    : master (requester side), slave (controller side)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_mp_ctrl_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_PORTS  = 2
);
  logic [NUM_PORTS-1:0]            valid;
  logic [NUM_PORTS-1:0]            wr_rd;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS*WIDTH-1:0]      wdata;
  logic [NUM_PORTS*(WIDTH/8)-1:0]  wstrb;
  logic [NUM_PORTS-1:0]            ready;
  logic [WIDTH-1:0]                rdata;
  logic                            err;

  modport master (
    output valid, wr_rd, addr, wdata, wstrb,
    input  ready, rdata, err
  );

  modport slave (
    input  valid, wr_rd, addr, wdata, wstrb,
    output ready, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_mp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_mp_ctrl
// Description : Multi-port word-addressed memory slave. NUM_PORTS requesters
//               share one storage array through a round-robin arbiter.
//               Supports byte write strobes, WAIT_STATES extra access
//               cycles and an error response for addresses >= DEPTH.
// Ports       :
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of mem_mp_ctrl_if (valid/wr_rd/addr/wdata/wstrb in,
//               ready/rdata/err out); all outputs are registered
// Revision    : 1.0 - initial release
// ============================================================================
module mem_mp_ctrl #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int NUM_PORTS   = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_mp_ctrl_if.slave bus
);

  localparam int NB = WIDTH / 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if (WIDTH % 8 != 0) begin : g_chk_width
    $error("mem_mp_ctrl: WIDTH must be a multiple of 8");
  end
  if (DEPTH > (1 << ADDR_WIDTH) || DEPTH < 1) begin : g_chk_depth
    $error("mem_mp_ctrl: DEPTH must be 1..2**ADDR_WIDTH");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_chk_ports
    $error("mem_mp_ctrl: NUM_PORTS must be 1..4");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_chk_wait
    $error("mem_mp_ctrl: WAIT_STATES must be 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                 state_q,      state_d;
  logic [3:0]             cnt_q,        cnt_d;
  logic [PW-1:0]          last_grant_q, last_grant_d;
  logic                   wr_q,         wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q,       addr_d;
  logic [WIDTH-1:0]       wdata_q,      wdata_d;
  logic [NB-1:0]          wstrb_q,      wstrb_d;
  logic [NUM_PORTS-1:0]   ready_q,      ready_d;
  logic [WIDTH-1:0]       rdata_q,      rdata_d;
  logic                   err_q,        err_d;

  // Storage array; intentionally not reset.
  logic [WIDTH-1:0]       mem [DEPTH];

  logic                   mem_we;
  logic [IW-1:0]          mem_idx;
  logic                   in_range;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: scan from last_grant+1 upward with wrap, so the
  // port served most recently gets the lowest priority next time.
  // --------------------------------------------------------------------------
  logic                   req_any;
  logic [PW-1:0]          req_sel;

  always_comb begin
    logic [PW-1:0] idx_p;
    int            idx;
    req_any = 1'b0;
    req_sel = last_grant_q;
    idx     = 0;
    idx_p   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx   = (int'(last_grant_q) + k) % NUM_PORTS;
      idx_p = PW'(idx);
      if (!req_any && bus.valid[idx_p]) begin
        req_any = 1'b1;
        req_sel = idx_p;
      end
    end
  end

  // Range check done one bit wider so DEPTH == 2**ADDR_WIDTH is representable.
  assign in_range = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(DEPTH));
  assign mem_idx  = addr_q[IW-1:0];

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    int base_a;
    int base_d;
    int base_s;
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    ready_d      = '0;          // ready is a single-cycle pulse
    rdata_d      = rdata_q;     // rdata holds unless a read/error updates it
    err_d        = 1'b0;
    mem_we       = 1'b0;
    base_a       = int'(req_sel) * ADDR_WIDTH;
    base_d       = int'(req_sel) * WIDTH;
    base_s       = int'(req_sel) * NB;

    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          // Capture the granted port's request now; later changes on its
          // inputs have no effect on this transaction.
          wr_d         = bus.wr_rd[req_sel];
          addr_d       = bus.addr[base_a +: ADDR_WIDTH];
          wdata_d      = bus.wdata[base_d +: WIDTH];
          wstrb_d      = bus.wstrb[base_s +: NB];
          last_grant_d = req_sel;
          cnt_d        = 4'(WAIT_STATES);
          state_d      = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d[last_grant_q] = 1'b1;
          state_d               = S_RESP;
          if (!in_range) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (wr_q) begin
            mem_we  = 1'b1;
          end else begin
            rdata_d = mem[mem_idx];
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= PW'(NUM_PORTS - 1);   // port 0 wins the first scan
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      ready_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Array write port. mem_we only asserts from ACCESS, and reset forces the
  // FSM to IDLE, so an abandoned transaction never reaches the array.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_q[b]) begin
          mem[mem_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_mp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_mp_ctrl
// Description : Directed self-checking bench for mem_mp_ctrl. Two instances:
//               dut_a (DEPTH=200, WAIT_STATES=0) and dut_b (DEPTH=256,
//               WAIT_STATES=3), both with two 32-bit ports.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_mp_ctrl;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  always #5 clk = ~clk;

  mem_mp_ctrl_if #(.WIDTH(32), .ADDR_WIDTH(8), .NUM_PORTS(2)) ia ();
  mem_mp_ctrl_if #(.WIDTH(32), .ADDR_WIDTH(8), .NUM_PORTS(2)) ib ();

  mem_mp_ctrl #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .NUM_PORTS(2), .WAIT_STATES(0))
    dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ia));

  mem_mp_ctrl #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .NUM_PORTS(2), .WAIT_STATES(3))
    dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ib));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] rdy(input int d);
    return (d == 0) ? ia.ready : ib.ready;
  endfunction

  function automatic logic [31:0] rdt(input int d);
    return (d == 0) ? ia.rdata : ib.rdata;
  endfunction

  function automatic logic erf(input int d);
    return (d == 0) ? ia.err : ib.err;
  endfunction

  task automatic drive(input int d, input int p, input logic wr, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    if (d == 0) begin
      ia.valid[p] = 1'b1; ia.wr_rd[p] = wr; ia.addr[p*8 +: 8] = a;
      ia.wdata[p*32 +: 32] = wd; ia.wstrb[p*4 +: 4] = ws;
    end else begin
      ib.valid[p] = 1'b1; ib.wr_rd[p] = wr; ib.addr[p*8 +: 8] = a;
      ib.wdata[p*32 +: 32] = wd; ib.wstrb[p*4 +: 4] = ws;
    end
  endtask

  task automatic drop(input int d, input int p);
    if (d == 0) ia.valid[p] = 1'b0;
    else        ib.valid[p] = 1'b0;
  endtask

  // One transaction on one port; lat counts edges from the first sampling
  // edge up to and including the edge after which ready is seen (0 = timeout).
  task automatic xact(input int d, input int p, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output logic er, output int lat);
    logic [1:0] r;
    drive(d, p, wr, a, wd, ws);
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      r = rdy(d);
      if (r[p]) begin
        lat = i; rd = rdt(d); er = erf(d);
        break;
      end
    end
    drop(d, p);
  endtask

  task automatic op(input string tag, input int d, input int p, input logic wr,
                    input logic [7:0] a, input logic [31:0] wd, input logic [3:0] ws,
                    input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(d, p, wr, a, wd, ws, rd, er, lat);
    chk({tag, "_lat"},   lat, exp_lat);
    chk({tag, "_err"},   {31'd0, er}, {31'd0, exp_err});
    chk({tag, "_rdata"}, rd, exp_rd);
    @(posedge clk); #1;
    chk({tag, "_rdy_pulse"}, {30'd0, rdy(d)}, 32'd0);
    chk({tag, "_err_clr"},   {31'd0, erf(d)}, 32'd0);
  endtask

  // Both ports request reads in the same cycle; reports who finished first,
  // when, and the spacing between the two completions.
  task automatic dual(input int d, input logic [7:0] a, output int first,
                      output int t_first, output int gap);
    logic [1:0] r;
    int t [2];
    bit done [2];
    t[0] = 0; t[1] = 0; done[0] = 0; done[1] = 0; first = -1;
    drive(d, 0, 1'b0, a, 32'd0, 4'hF);
    drive(d, 1, 1'b0, a, 32'd0, 4'hF);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      r = rdy(d);
      for (int p = 0; p < 2; p++) begin
        if (r[p] && !done[p]) begin
          done[p] = 1; t[p] = i; drop(d, p);
          if (first < 0) first = p;
        end
      end
      if (done[0] && done[1]) break;
    end
    drop(d, 0); drop(d, 1);
    t_first = (first == 1) ? t[1] : t[0];
    gap     = (first == 1) ? t[0] - t[1] : t[1] - t[0];
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, tf, gap;
    bit seen;
    ia.valid = '0; ia.wr_rd = '0; ia.addr = '0; ia.wdata = '0; ia.wstrb = '0;
    ib.valid = '0; ib.wr_rd = '0; ib.addr = '0; ib.wdata = '0; ib.wstrb = '0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_ready", {30'd0, ia.ready}, 32'd0);
    chk("a_rst_rdata", ia.rdata, 32'd0);
    chk("a_rst_err",   {31'd0, ia.err}, 32'd0);
    chk("b_rst_ready", {30'd0, ib.ready}, 32'd0);
    rst_a_n = 1'b1;

    // ---------------- basic write/read, strobes, range (dut_a) ----------------
    op("wr10",  0, 0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0, 2);
    op("rd10",  0, 0, 1'b0, 8'h10, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2);
    op("wr20a", 0, 1, 1'b1, 8'h20, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0, 2);
    op("wr20b", 0, 1, 1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0, 2);
    op("rd20",  0, 0, 1'b0, 8'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 2);
    op("wr20z", 0, 1, 1'b1, 8'h20, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0, 2);
    op("rd20z", 0, 1, 1'b0, 8'h20, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, 2);
    op("wrC7",  0, 0, 1'b1, 8'hC7, 32'h5A5A5A5A, 4'hF, 32'h11BB33DD, 1'b0, 2);
    op("rdC8",  0, 0, 1'b0, 8'hC8, 32'h0,        4'hF, 32'h00000000, 1'b1, 2);
    op("wrC8",  0, 1, 1'b1, 8'hC8, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1, 2);
    op("rdC7",  0, 1, 1'b0, 8'hC7, 32'h0,        4'hF, 32'h5A5A5A5A, 1'b0, 2);
    op("rdFF",  0, 0, 1'b0, 8'hFF, 32'h0,        4'hF, 32'h00000000, 1'b1, 2);
    op("rd10b", 0, 1, 1'b0, 8'h10, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2);

    // ---------------- arbitration after reset (dut_a) ----------------
    rst_a_n = 1'b0;
    #1;
    chk("a_rst2_rdata", ia.rdata, 32'd0);
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    dual(0, 8'h10, first, tf, gap);
    chk("arb1_first", first, 0);
    chk("arb1_lat",   tf,    2);
    chk("arb1_gap",   gap,   3);
    op("arb_p0", 0, 0, 1'b0, 8'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 2);
    dual(0, 8'h10, first, tf, gap);
    chk("arb2_first", first, 1);
    chk("arb2_gap",   gap,   3);

    // ---------------- wait states (dut_b) ----------------
    rst_b_n = 1'b1;
    op("b_wr30", 1, 0, 1'b1, 8'h30, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0, 5);
    op("b_rd30", 1, 1, 1'b0, 8'h30, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0, 5);
    op("b_wrFF", 1, 0, 1'b1, 8'hFF, 32'h0BADC0DE, 4'hF, 32'hCAFEF00D, 1'b0, 5);
    op("b_rdFF", 1, 1, 1'b0, 8'hFF, 32'h0,        4'hF, 32'h0BADC0DE, 1'b0, 5);
    dual(1, 8'h30, first, tf, gap);
    chk("b_arb_first", first, 0);
    chk("b_arb_gap",   gap,   6);

    // ---------------- reset in the middle of a write (dut_b) ----------------
    drive(1, 1, 1'b1, 8'h30, 32'h12345678, 4'hF);
    @(posedge clk); #1;   // grant edge
    @(posedge clk); #1;   // first wait cycle
    rst_b_n = 1'b0;
    drop(1, 1);
    #1;
    chk("b_mid_ready", {30'd0, ib.ready}, 32'd0);
    chk("b_mid_rdata", ib.rdata, 32'd0);
    chk("b_mid_err",   {31'd0, ib.err}, 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ib.ready != 2'b00) seen = 1'b1;
    end
    chk("b_mid_no_ready", {31'd0, seen}, 32'd0);
    rst_b_n = 1'b1;
    op("b_rd30_old", 1, 0, 1'b0, 8'h30, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
